// File: rtl/t07_mem_arbiter_if.sv
// rtl/t07_mem_arbiter_if.sv - requester and wishbone-manager signals of the memory arbiter
// slave is the arbiter's view; master is the view of the surrounding CPU/MMIO/manager.
interface t07_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_data;
  logic [1:0]        data_rwi;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_sel;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;
  logic              mgr_read;
  logic              mgr_write;
  logic [ADDR_W-1:0] mgr_addr;
  logic [DATA_W-1:0] mgr_wdata;
  logic [3:0]        mgr_sel;
  logic              mgr_busy;
  logic [DATA_W-1:0] mgr_rdata;
  logic              owner;
  logic              timeout_err;

  modport slave (
    input  fetch_req, fetch_addr, data_rwi, data_addr, data_wdata, data_sel, mgr_busy, mgr_rdata,
    output fetch_done, fetch_data, data_done, data_rdata, mgr_read, mgr_write, mgr_addr,
           mgr_wdata, mgr_sel, owner, timeout_err
  );

  modport master (
    output fetch_req, fetch_addr, data_rwi, data_addr, data_wdata, data_sel, mgr_busy, mgr_rdata,
    input  fetch_done, fetch_data, data_done, data_rdata, mgr_read, mgr_write, mgr_addr,
           mgr_wdata, mgr_sel, owner, timeout_err
  );
endinterface

// File: rtl/t07_mem_arbiter.sv
// rtl/t07_mem_arbiter.sv - round-robin fetch/data arbiter in front of the wishbone manager
// One transaction at a time: IDLE grant, ISSUE strobe, WAIT_HI/WAIT_LO busy handshake, done.
module t07_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  t07_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              is_write_q, is_write_d;
  logic              busy_seen_q, busy_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              fetch_done_q, fetch_done_d;
  logic              data_done_q, data_done_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              fetch_valid, data_valid, grant_data, finish, abort;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    busy_seen_d  = busy_seen_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    timeout_d    = 1'b0;
    grant_data   = 1'b0;
    finish       = 1'b0;
    abort        = 1'b0;
    fetch_valid  = bus.fetch_req;
    data_valid   = bus.data_rwi[1] ^ bus.data_rwi[0];

    case (state_q)
      IDLE: begin
        if (fetch_valid || data_valid) begin
          // owner doubles as the round-robin pointer: on contention the last loser wins
          grant_data = data_valid && (!fetch_valid || !owner_q);
          owner_d    = grant_data;
          if (grant_data) begin
            addr_d     = bus.data_addr;
            wdata_d    = bus.data_wdata;
            sel_d      = bus.data_sel;
            is_write_d = (bus.data_rwi == 2'b01);
          end else begin
            addr_d     = bus.fetch_addr;
            wdata_d    = '0;
            sel_d      = 4'hF;
            is_write_d = 1'b0;
          end
          read_d  = !is_write_d;
          write_d = is_write_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // a manager that raises busy during the strobe cycle may drop it before WAIT_HI samples
        busy_seen_d = bus.mgr_busy;
        cnt_d       = '0;
        state_d     = WAIT_HI;
      end
      WAIT_HI, WAIT_LO: begin
        if (state_q == WAIT_LO && !bus.mgr_busy) begin
          finish = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == WAIT_HI && (bus.mgr_busy || busy_seen_q)) state_d = WAIT_LO;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish || abort) begin
      state_d      = IDLE;
      timeout_d    = abort;
      fetch_done_d = !owner_q;
      data_done_d  = owner_q;
      if (abort) begin
        if (owner_q) data_rdata_d = '0;
        else         fetch_data_d = '0;
      end else if (!is_write_q) begin
        if (owner_q) data_rdata_d = bus.mgr_rdata;
        else         fetch_data_d = bus.mgr_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      busy_seen_q  <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      timeout_q    <= 1'b0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      busy_seen_q  <= busy_seen_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      read_q       <= read_d;
      write_q      <= write_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      timeout_q    <= timeout_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus.mgr_read    = read_q;
  assign bus.mgr_write   = write_q;
  assign bus.mgr_addr    = addr_q;
  assign bus.mgr_wdata   = wdata_q;
  assign bus.mgr_sel     = sel_q;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.data_done   = data_done_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_q;
endmodule
